scu_pipe: RTL and testbench

Parametrised pipeline stall/flush control unit, successor to the fixed 4-stage stall controller. Merges per-stage level stall requests and a self-timed multi-cycle stall (for fixed-latency units such as divider/multiplier) into a stall vector covering PC through the requesting stage. Adds a prioritised, multi-cycle pipeline flush and a saturating stall-cycle performance counter. Sits beside the datapath; its stall/flush vectors drive every pipeline register enable and clear.

---
 rtl/scu_pipe_if.sv | 29 ++
 rtl/scu_pipe.sv | 115 +++++++++++
 tb/tb_scu_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/scu_pipe_if.sv
// Request/response bundle between the pipeline datapath and the stall/flush control unit.
// master = datapath side (drives requests), slave = scu_pipe.
interface scu_pipe_if #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
);
    localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [STAGES-1:0] stallreq;
    logic              tstall_start;
    logic [SEL_W-1:0]  tstall_stage;
    logic [CNT_W-1:0]  tstall_len;
    logic              flush_req;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              tstall_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq, tstall_start, tstall_stage, tstall_len, flush_req,
        input  stall, flush, tstall_busy, stall_cycles
    );

    modport slave (
        input  stallreq, tstall_start, tstall_stage, tstall_len, flush_req,
        output stall, flush, tstall_busy, stall_cycles
    );
endinterface

// File: rtl/scu_pipe.sv
// Pipeline stall/flush control: merges level stall requests with a self-timed stall,
// applies a prioritised multi-cycle flush and counts stalled cycles (saturating).
module scu_pipe #(
    parameter int STAGES       = 4,
    parameter int CNT_W        = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst,
    scu_pipe_if.slave  bus
);
    localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {IDLE, RUN} tstate_e;

    tstate_e           state_q, state_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [SEL_W-1:0]  tstage_q, tstage_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    logic              flush_active;
    logic              start_ok;
    logic              hit;
    logic              stall_now;
    logic [STAGES-1:0] eff;
    logic [STAGES-1:0] stall_mask;

    assign flush_active = bus.flush_req || (fcnt_q != '0);
    assign start_ok     = bus.tstall_start && (bus.tstall_len != '0)
                          && (int'(bus.tstall_stage) < STAGES);

    // Stall everything from PC up to the highest requesting stage.
    always_comb begin
        eff = bus.stallreq;
        if (state_q == RUN) begin
            eff[tstage_q] = 1'b1;
        end
        hit        = 1'b0;
        stall_mask = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hit           = hit | eff[k];
            stall_mask[k] = hit;
        end
    end

    assign stall_now = stall_mask[0] && !flush_active;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        tstage_d = tstage_q;
        fcnt_d   = fcnt_q;
        perf_d   = perf_q;

        if (bus.flush_req) begin
            fcnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_ok && !flush_active) begin
                    state_d  = RUN;
                    tcnt_d   = bus.tstall_len;
                    tstage_d = bus.tstall_stage;
                end
            end
            RUN: begin
                if (bus.flush_req) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                    if (tcnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stall_now && (perf_q != '1)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            tstage_q <= '0;
            fcnt_q   <= '0;
            perf_q   <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            tstage_q <= tstage_d;
            fcnt_q   <= fcnt_d;
            perf_q   <= perf_d;
        end
    end

    // Reset forces the control outputs low in the same cycle, ahead of the clearing edge.
    assign bus.tstall_busy  = !cpu_rst && (state_q == RUN);
    assign bus.flush        = cpu_rst ? '0 : {STAGES{flush_active}};
    assign bus.stall        = (cpu_rst || flush_active) ? '0 : stall_mask;
    assign bus.stall_cycles = perf_q;

endmodule

// File: tb/tb_scu_pipe.sv
// Self-checking bench for scu_pipe: two configurations driven by directed and random
// stimulus, compared every cycle against a cycle-count reference model.
module tb_scu_pipe;

    typedef struct packed {
        logic [7:0] req;
        logic       start;
        logic [2:0] stage;
        logic [5:0] len;
        logic       freq;
    } stim_t;

    typedef struct {
        int trem;   // timed-stall cycles still to run
        int owner;  // stage owning the timed stall
        int frem;   // flush cycles still to come after this one
        int perf;
    } mstate_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    stim_t   sa, sb;
    mstate_t ma, mb;
    int      total = 0;
    int      bad   = 0;

    always #5 clk = ~clk;

    // A: STAGES=4, FLUSH_CYCLES=3, PERF_W=4.  B: STAGES=5, FLUSH_CYCLES=1, PERF_W=8.
    scu_pipe_if #(.STAGES(4), .CNT_W(6), .PERF_W(4)) ifa ();
    scu_pipe_if #(.STAGES(5), .CNT_W(4), .PERF_W(8)) ifb ();

    scu_pipe #(.STAGES(4), .CNT_W(6), .FLUSH_CYCLES(3), .PERF_W(4)) dut_a (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (ifa.slave)
    );

    scu_pipe #(.STAGES(5), .CNT_W(4), .FLUSH_CYCLES(1), .PERF_W(8)) dut_b (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .bus         (ifb.slave)
    );

    assign ifa.stallreq     = sa.req[3:0];
    assign ifa.tstall_start = sa.start;
    assign ifa.tstall_stage = sa.stage[1:0];
    assign ifa.tstall_len   = sa.len;
    assign ifa.flush_req    = sa.freq;

    assign ifb.stallreq     = sb.req[4:0];
    assign ifb.tstall_start = sb.start;
    assign ifb.tstall_stage = sb.stage;
    assign ifb.tstall_len   = sb.len[3:0];
    assign ifb.flush_req    = sb.freq;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs for the current cycle, from the model state and the live inputs.
    function automatic void mcomb(input mstate_t m, input int s_n, input logic r, input stim_t s,
                                  output int st, output int fl, output int busy);
        int  eff;
        int  h;
        bit  flush_now;
        st = 0; fl = 0; busy = 0;
        if (r) return;
        flush_now = s.freq || (m.frem > 0);
        busy      = (m.trem > 0) ? 1 : 0;
        eff       = int'(s.req) & ((1 << s_n) - 1);
        if (busy != 0) eff = eff | (1 << m.owner);
        h = -1;
        for (int k = 0; k < s_n; k++) begin
            if (((eff >> k) & 1) != 0) h = k;
        end
        fl = flush_now ? (1 << s_n) - 1 : 0;
        st = (flush_now || h < 0) ? 0 : (1 << (h + 1)) - 1;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input int s_n, input int f_n, input int pw,
                                      input logic r, input stim_t s, input int st);
        mstate_t n;
        bit      flush_now;
        n = m;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        if ((st & 1) != 0 && n.perf < (1 << pw) - 1) n.perf++;
        flush_now = s.freq || (m.frem > 0);
        if (s.freq) begin
            n.frem = f_n - 1;
            n.trem = 0;
        end else begin
            if (m.frem > 0) n.frem--;
            if (m.trem > 0) n.trem--;
            else if (s.start && s.len != 0 && int'(s.stage) < s_n && !flush_now) begin
                n.trem  = int'(s.len);
                n.owner = int'(s.stage);
            end
        end
        return n;
    endfunction

    // Check both DUTs mid-cycle, then advance the models across the rising edge.
    task automatic tick();
        int st_a, fl_a, bz_a, st_b, fl_b, bz_b;
        @(negedge clk);
        mcomb(ma, 4, rst, sa, st_a, fl_a, bz_a);
        mcomb(mb, 5, rst, sb, st_b, fl_b, bz_b);
        check("a_stall", ifa.stall, st_a);
        check("a_flush", ifa.flush, fl_a);
        check("a_busy",  ifa.tstall_busy, bz_a);
        check("a_perf",  ifa.stall_cycles, ma.perf);
        check("b_stall", ifb.stall, st_b);
        check("b_flush", ifb.flush, fl_b);
        check("b_busy",  ifb.tstall_busy, bz_b);
        check("b_perf",  ifb.stall_cycles, mb.perf);
        @(posedge clk);
        ma = mstep(ma, 4, 3, 4, rst, sa, st_a);
        mb = mstep(mb, 5, 1, 8, rst, sb, st_b);
        #1;
    endtask

    // Same stimulus to both DUTs; start/flush are single-cycle pulses, req is held.
    task automatic drive(input logic r, input logic [7:0] req, input logic start,
                         input logic [2:0] stage, input logic [5:0] len, input logic freq,
                         input int n);
        rst = r;
        sa  = '{req: req, start: start, stage: stage, len: len, freq: freq};
        sb  = sa;
        for (int i = 0; i < n; i++) begin
            tick();
            sa.start = 1'b0; sa.freq = 1'b0;
            sb.start = 1'b0; sb.freq = 1'b0;
        end
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        sa = '0;
        sb = '0;
        #1;

        drive(1, 8'h00, 0, 0, 0, 0, 2);
        drive(0, 8'b0100, 0, 0, 0, 0, 1);
        check("tp_req_0100", ifa.stall, 4'b0111);
        drive(0, 8'b1010, 0, 0, 0, 0, 1);
        check("tp_req_1010", ifa.stall, 4'b1111);
        drive(0, 8'h00, 0, 0, 0, 0, 1);
        check("tp_req_0", ifa.stall, 4'b0000);

        drive(1, 8'h00, 0, 0, 0, 0, 1);
        drive(0, 8'h00, 1, 3, 5, 0, 2);
        drive(0, 8'h00, 1, 3, 9, 0, 8);
        check("tp_tstall_perf", ifa.stall_cycles, 5);
        check("tp_tstall_done", ifa.tstall_busy, 0);

        drive(0, 8'h00, 1, 2, 0, 0, 3);
        check("tp_len0_stall", ifa.stall, 0);

        drive(0, 8'b1000, 0, 0, 0, 1, 5);
        check("tp_flush_after", ifa.stall, 4'b1111);
        check("tp_flush_clear", ifa.flush, 0);
        drive(0, 8'h00, 0, 0, 0, 0, 3);

        drive(0, 8'h00, 1, 1, 5, 0, 2);
        drive(0, 8'h00, 0, 0, 0, 1, 1);
        check("tp_abort_busy", ifa.tstall_busy, 0);
        drive(0, 8'h00, 0, 0, 0, 0, 3);
        drive(0, 8'h00, 1, 1, 5, 1, 4);
        check("tp_simul_busy", ifa.tstall_busy, 0);

        drive(0, 8'b0001, 0, 0, 0, 0, 20);
        check("tp_perf_sat", ifa.stall_cycles, 15);

        drive(0, 8'h00, 1, 3, 7, 0, 3);
        drive(1, 8'b0010, 0, 0, 0, 1, 1);
        drive(0, 8'h00, 0, 0, 0, 0, 1);
        check("tp_rst_perf", ifa.stall_cycles, 0);
        check("tp_rst_busy", ifa.tstall_busy, 0);

        // Out-of-range owner on the 5-stage instance is ignored.
        sb = '{req: 8'h00, start: 1'b1, stage: 3'd6, len: 6'd3, freq: 1'b0};
        tick();
        sb.start = 1'b0;
        tick();
        check("tp_stage_range", ifb.tstall_busy, 0);

        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(99) == 0);
            sa.req   = ($urandom_range(3) == 0) ? 8'($urandom_range(15)) : 8'h00;
            sa.start = ($urandom_range(5) == 0);
            sa.stage = 3'($urandom_range(3));
            sa.len   = 6'($urandom_range(10));
            sa.freq  = ($urandom_range(15) == 0);
            sb.req   = ($urandom_range(3) == 0) ? 8'($urandom_range(31)) : 8'h00;
            sb.start = ($urandom_range(5) == 0);
            sb.stage = 3'($urandom_range(7));
            sb.len   = 6'($urandom_range(15));
            sb.freq  = ($urandom_range(15) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
